// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: round-robin arbiter feeding a byte-serial 8-bit RAM/IO port.
// Define MEMCTRL_FLUSH_EN to add the flush input that aborts abortable reads.
module mem_arbiter_ctrl #(
    parameter int unsigned          NUM_PORTS  = 2,
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [31:0]          IO_BASE    = 32'h0003_0000,
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 2'b01
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        io_buffer_full,
`ifdef MEMCTRL_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [ADDR_W-1:0]           mem_a,
    output logic                        mem_wr,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [3*NUM_PORTS-1:0]      len,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0]     wdata,
    output logic [31:0]                 rdata,
    output logic [NUM_PORTS-1:0]        done
);

    localparam int unsigned       PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W-1:0] LP_IO_BASE = ADDR_W'(IO_BASE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]           r_state;
    logic [2:0]           r_cnt;
    logic [2:0]           r_len;
    logic [PW-1:0]        r_rr_ptr;
    logic [PW-1:0]        r_port;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_wdata;

    logic                 w_flush;
    logic                 w_flush_rd;
    logic [NUM_PORTS-1:0] w_req_eff;
    logic                 w_gnt_valid;
    logic [PW-1:0]        w_gnt_idx;
    int unsigned          w_scan;
    logic [2:0]           w_gnt_len_raw;
    logic [2:0]           w_gnt_len;
    logic [ADDR_W-1:0]    w_gnt_addr;
    logic                 w_stall;
    logic [1:0]           w_rd_sel;

`ifdef MEMCTRL_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A port still showing its done pulse is excluded so it cannot be re-granted before dropping req.
    assign w_req_eff  = req & ~done & ~(w_flush ? FLUSH_MASK : '0);
    assign w_flush_rd = w_flush & FLUSH_MASK[r_port];
    assign w_stall    = io_buffer_full && (r_addr >= LP_IO_BASE);
    assign w_rd_sel   = r_cnt[1:0] - 2'd1;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_scan = (32'(r_rr_ptr) + k) % NUM_PORTS;
            if (!w_gnt_valid && w_req_eff[PW'(w_scan)]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = PW'(w_scan);
            end
        end
    end

    always_comb begin
        w_gnt_len_raw = len[3*w_gnt_idx +: 3];
        w_gnt_addr    = addr[ADDR_W*w_gnt_idx +: ADDR_W];
        case (w_gnt_len_raw)
            3'd1:    w_gnt_len = 3'd1;
            3'd2:    w_gnt_len = 3'd2;
            default: w_gnt_len = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_len    <= 3'd4;
            r_rr_ptr <= PW'(NUM_PORTS - 1);
            r_port   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            rdata    <= '0;
            done     <= '0;
        end else if (!rdy) begin
            done   <= '0;
            mem_wr <= 1'b0;
        end else begin
            done   <= '0;
            mem_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_port   <= w_gnt_idx;
                        r_rr_ptr <= w_gnt_idx;
                        r_cnt    <= '0;
                        r_len    <= w_gnt_len;
                        r_addr   <= w_gnt_addr;
                        r_wdata  <= wdata[32*w_gnt_idx +: 32];
                        if (we[w_gnt_idx]) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                            mem_a   <= w_gnt_addr;
                            rdata   <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (w_flush_rd) begin
                        r_state <= ST_IDLE;
                        mem_a   <= '0;
                    end else begin
                        // Address runs one byte ahead of capture because RAM data lags its address by a cycle.
                        if (r_cnt < r_len - 3'd1) mem_a <= r_addr + ADDR_W'(r_cnt) + ADDR_W'(1);
                        if (r_cnt != 3'd0) rdata[{w_rd_sel, 3'b000} +: 8] <= mem_din;
                        if (r_cnt == r_len) begin
                            done[r_port] <= 1'b1;
                            r_state      <= ST_IDLE;
                            mem_a        <= '0;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == r_len) begin
                        done[r_port] <= 1'b1;
                        r_state      <= ST_IDLE;
                        mem_a        <= '0;
                    end else if (!w_stall) begin
                        mem_a    <= r_addr + ADDR_W'(r_cnt);
                        mem_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                        mem_wr   <= 1'b1;
                        r_cnt    <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: expected completions and write bytes are queued
// at stimulus time and checked as the DUT emits done pulses and mem_wr cycles.
module tb_mem_arbiter_ctrl;

    localparam int NP = 2;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b1;
    logic            io_buffer_full = 1'b0;
`ifdef MEMCTRL_FLUSH_EN
    logic            flush = 1'b0;
`endif
    logic [7:0]      mem_din = '0;
    logic [7:0]      mem_dout;
    logic [AW-1:0]   mem_a;
    logic            mem_wr;
    logic [NP-1:0]   req = '0;
    logic [NP-1:0]   we = '0;
    logic [3*NP-1:0] len = '0;
    logic [32*NP-1:0] addr = '0;
    logic [32*NP-1:0] wdata = '0;
    logic [31:0]     rdata;
    logic [NP-1:0]   done;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .IO_BASE   (32'h0003_0000),
        .FLUSH_MASK(2'b01)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .io_buffer_full(io_buffer_full),
`ifdef MEMCTRL_FLUSH_EN
        .flush         (flush),
`endif
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .req           (req),
        .we            (we),
        .len           (len),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .done          (done)
    );

    bit [7:0] ram    [0:262143];
    bit [7:0] shadow [0:262143];

    // The RAM's read register shares the global ready, so frozen cycles keep mem_din stable.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        if (rdy) mem_din <= ram[mem_a[17:0]];
    end

    typedef struct {
        int          port;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t sb[$];
    wr_t  exp_wr[$];
    exp_t mon_e;
    wr_t  mon_w;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'(a) ^ 8'h5A;
    endfunction

    task automatic set_port(input int p, input bit w, input logic [2:0] l,
                            input logic [31:0] a, input logic [31:0] d);
        we[p]            = w;
        len[3*p +: 3]    = l;
        addr[32*p +: 32] = a;
        wdata[32*p +: 32] = d;
    endtask

    task automatic push_txn(input int p, input bit w, input logic [2:0] l,
                            input logic [31:0] a, input logic [31:0] d);
        int          n;
        exp_t        e;
        wr_t         x;
        logic [31:0] rd;
        logic [31:0] ai;
        n  = (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
        rd = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            if (w) begin
                x.a = ai;
                x.d = d[8*i +: 8];
                exp_wr.push_back(x);
                shadow[ai[17:0]] = x.d;
            end else begin
                rd[8*i +: 8] = shadow[ai[17:0]];
            end
        end
        e.port   = p;
        e.chk_rd = !w;
        e.rd     = rd;
        sb.push_back(e);
    endtask

    // Returns the number of falling edges from raising req to seeing done (grant + L + 1).
    task automatic run_txn(input int p, input bit w, input logic [2:0] l,
                           input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        set_port(p, w, l, a, d);
        push_txn(p, w, l, a, d);
        req[p] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done[p] && lat < 60);
        req[p] = 1'b0;
        if (!done[p]) check("txn_timeout", 64'(done), 64'(1 << p));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done != '0) begin
            check("done_onehot", 64'($countones(done)), 1);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_port", 64'(done), 64'(1 << mon_e.port));
                if (mon_e.chk_rd) check("rdata", rdata, mon_e.rd);
            end
        end
        if (mem_wr) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_wr", mem_wr, 0);
            end else begin
                mon_w = exp_wr.pop_front();
                check("wr_addr", mem_a, mon_w.a);
                check("wr_byte", mem_dout, mon_w.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int cyc;

        for (int i = 0; i < 262144; i++) begin
            ram[i]    = init_byte(i);
            shadow[i] = init_byte(i);
        end
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h93;
        shadow[32'h100] = 8'h13; shadow[32'h101] = 8'h00; shadow[32'h102] = 8'h00; shadow[32'h103] = 8'h93;

        apply_reset();

        run_txn(0, 1'b0, 3'd4, 32'h100, 32'h0, lat);
        check("rd4_latency", lat, 6);

        run_txn(1, 1'b1, 3'd2, 32'h200, 32'hDEADBEEF, lat);
        check("wr2_latency", lat, 4);
        check("wr2_byte0_ram", ram[32'h200], 8'hEF);
        check("wr2_untouched_202", ram[32'h202], init_byte(32'h202));

        apply_reset();
        @(negedge clk);
        set_port(0, 1'b0, 3'd4, 32'h100, 32'h0);
        set_port(1, 1'b0, 3'd2, 32'h200, 32'h0);
        push_txn(0, 1'b0, 3'd4, 32'h100, 32'h0);
        push_txn(1, 1'b0, 3'd2, 32'h200, 32'h0);
        push_txn(0, 1'b0, 3'd4, 32'h100, 32'h0);
        push_txn(1, 1'b0, 3'd2, 32'h200, 32'h0);
        req = 2'b11;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done != '0) k++;
        end
        req = '0;
        check("rr_done_count", k, 4);

        run_txn(0, 1'b0, 3'd3, 32'h100, 32'h0, lat);
        check("len3_as_4_latency", lat, 6);
        run_txn(1, 1'b1, 3'd0, 32'h300, 32'h44332211, lat);
        check("len0_as_4_latency", lat, 6);

        // IO write held off for three cycles by a full buffer
        @(negedge clk);
        set_port(1, 1'b1, 3'd1, 32'h30000, 32'h77);
        push_txn(1, 1'b1, 3'd1, 32'h30000, 32'h77);
        io_buffer_full = 1'b1;
        req[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_mem_wr", mem_wr, 0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("stall_release_wr", mem_wr, 1);
        check("stall_release_a", mem_a, 32'h30000);
        @(negedge clk);
        check("stall_done", done, 2'b10);
        req[1] = 1'b0;

        io_buffer_full = 1'b1;
        run_txn(1, 1'b1, 3'd1, 32'h1000, 32'h3C, lat);
        check("ram_write_nostall_latency", lat, 3);
        io_buffer_full = 1'b0;

        run_txn(1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000A55A, lat);
        check("wrap_wr_latency", lat, 4);
        run_txn(0, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0, lat);
        check("wrap_rd_latency", lat, 4);

        // Freeze a len=4 read for two cycles after its first byte is captured
        @(negedge clk);
        set_port(0, 1'b0, 3'd4, 32'h100, 32'h0);
        push_txn(0, 1'b0, 3'd4, 32'h100, 32'h0);
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("frz_pre_a", mem_a, 32'h102);
        rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("frz_mem_a", mem_a, 32'h102);
            check("frz_done", done, 0);
        end
        rdy = 1'b1;
        lat = 0;
        while (!done[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        req[0] = 1'b0;
        check("frz_resume_latency", lat, 3);

`ifdef MEMCTRL_FLUSH_EN
        @(negedge clk);
        set_port(0, 1'b0, 3'd4, 32'h100, 32'h0);
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        set_port(1, 1'b0, 3'd1, 32'h100, 32'h0);
        push_txn(1, 1'b0, 3'd1, 32'h100, 32'h0);
        req[1] = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req[0] = 1'b0;
        check("flush_idle_a", mem_a, 0);
        check("flush_no_done", done, 0);
        @(negedge clk);
        check("flush_regrant_a", mem_a, 32'h100);
        lat = 0;
        while (!done[1] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        req[1] = 1'b0;
        check("flush_port1_done", done, 2'b10);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("wr_q_drained", exp_wr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Parametrised, byte-serial memory controller arbitrating NUM_PORTS requesters (port 0 = IF fetch, port 1 = LSB, others spare) onto a single 8-bit RAM/IO port.
- Replaces pulse-and-buffer request capture with level-held req/done handshakes and round-robin arbitration.
- Supports 1/2/4-byte reads and writes; stalls only on IO-region writes while the IO buffer is full.
- Sits between the fetch/LSB units and the top-level RAM/IO mux.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO; only these stall on io_buffer_full.
- FLUSH_MASK, 2'b01, one bit per port; set = port's reads are abortable by flush (with MEMCTRL_FLUSH_EN only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes the block
- io_buffer_full  in  1  IO write buffer full
- mem_din  in  8  RAM read byte, valid one cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  ADDR_W  byte address
- mem_wr  out  1  1 = write, 0 = read
- req  in  NUM_PORTS  per-port request, held high until done
- we  in  NUM_PORTS  per-port write flag
- len  in  3*NUM_PORTS  byte count per port: 1, 2 or 4
- addr  in  ADDR_W*NUM_PORTS  per-port start address
- wdata  in  32*NUM_PORTS  per-port write data
- rdata  out  32  read result, zero-extended, shared
- done  out  NUM_PORTS  one-hot, one-cycle completion pulse

Behaviour:
- Reset values: mem_a=0, mem_wr=0, mem_dout=0, rdata=0, done=0.
  - Internally: state=IDLE, cnt=0, rr_ptr=NUM_PORTS-1, so port 0 wins first.
- States: IDLE, READ, WRITE.
- IDLE arbitration:
  - Grant the first port i with req[i]=1, scanning cyclically from rr_ptr+1.
  - Latch we/len/addr/wdata of port i; rr_ptr<=i; cnt<=0.
  - Masking: a port whose done bit is high this cycle is excluded; done is always driven in IDLE.
  - Illegal len (0, 3, >4) is treated as 4.
- READ, len = L:
  - Grant edge: mem_a<=addr, mem_wr<=0.
  - Each BUSY edge with cnt=c:
    - If c<L-1, drive mem_a<=addr+c+1.
    - If c>=1, capture mem_din into rdata byte c-1; when c=L, capture into byte L-1.
  - At c=L: done[i]<=1, state<=IDLE, mem_a<=0.
  - done rises L+1 cycles after the grant edge.
  - rdata bytes >= L are zero; rdata is cleared at grant.
- WRITE, len = L:
  - BUSY edge with cnt=c<L: mem_a<=addr+c, mem_dout<=wdata byte c, mem_wr<=1.
  - At c=L: mem_wr<=0, mem_a<=0, done[i]<=1, state<=IDLE.
  - Address arithmetic wraps mod 2^ADDR_W.
- Stall: in WRITE, if io_buffer_full=1 and latched addr >= IO_BASE:
  - Hold cnt and mem_a; mem_wr<=0 for that cycle; no byte is issued.
  - Resume exactly where stalled.
  - Reads and RAM-region writes never stall.
- rdy=0: all state, counters and outputs hold, except done<=0 and mem_wr<=0. Operation resumes seamlessly on rdy=1.
- Requests:
  - req may rise in any state and is served once IDLE.
  - Simultaneous requests are resolved round-robin; no starvation (max wait NUM_PORTS-1 transactions).
  - Dropping req mid-transaction is ignored; the transaction completes and done still pulses.
- rst mid-transaction: aborts immediately to reset values; no done pulse; a partial write may have reached RAM.
- done is never asserted on two ports in the same cycle.

Optional Feature:
- MEMCTRL_FLUSH_EN defined:
  - Adds input flush (1 bit).
  - flush=1 while in READ for a port with FLUSH_MASK bit set: state<=IDLE, mem_a<=0, no done, rdata unchanged.
  - Also in that cycle, req of all FLUSH_MASK ports is ignored in IDLE arbitration.
  - WRITE and unmasked-port reads are unaffected.
- Undefined: no flush port; every granted transaction completes.

Test Plan:
- Port 0 read len=4 at 0x100, RAM holds 13 00 00 93 at 0x100..0x103 -> done[0] 5 cycles after grant, rdata=0x93000013.
- Port 1 write len=2 addr 0x200 wdata 0xDEADBEEF -> mem_wr=1 with (0x200, EF) then (0x201, BE); done[1] after 2 bytes; 0x202 untouched.
- req=2'b11 held continuously, 4 transactions -> grants alternate 0, 1, 0, 1, starting with port 0 after reset.
- Port 1 write len=1 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr low for those cycles, byte issued after release, done one cycle later; same with addr 0x1000 -> no stall.
- rdy low 2 cycles mid read len=4 -> mem_a/cnt frozen, done stays 0, final rdata correct.
- MEMCTRL_FLUSH_EN: flush during port 0 read cnt=2 -> no done[0], IDLE next cycle, pending port 1 granted.
